cordic_iter_rotate: RTL and testbench

CORDIC_ITER_ROTATE -- requirements
Module: cordic_iter_rotate

---
 rtl/cordic_pkg.sv | 37 +++
 rtl/cordic_micro_rotate.sv | 23 ++
 rtl/cordic_iter_rotate.sv | 104 ++++++++++
 tb/tb_cordic_iter_rotate.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC constants, arctangent table and FSM state type
package cordic_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ROT, HOLD} state_e;
  localparam int ITER_MAX = 17;
  // atan(2^-i) scaled so that 2^31 = 180 deg
  function automatic logic [31:0] atan_raw(int i);
    case (i)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2F9;
      15:      return 32'h0000_517C;
      16:      return 32'h0000_28BE;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] atan_tab(int i, int dsize);
    return 32'((64'(atan_raw(i)) + (64'd1 << (31 - dsize))) >> (32 - dsize));
  endfunction
  function automatic logic [31:0] ang_90(int dsize);
    return 32'd1 << (dsize - 2);
  endfunction
  function automatic int iter_clamp(int n);
    return n < 1 ? 1 : n > ITER_MAX ? ITER_MAX : n;
  endfunction
endpackage

// File: rtl/cordic_micro_rotate.sv
// cordic_micro_rotate: one combinational rotation-mode CORDIC iteration
module cordic_micro_rotate #(
  parameter int W  = 18,
  parameter int ZW = 16
) (
  input  logic [W-1:0]  x_i,
  input  logic [W-1:0]  y_i,
  input  logic [ZW-1:0] z_i,
  input  logic [ZW-1:0] atan_i,
  input  logic [4:0]    sel_i,
  output logic [W-1:0]  x_o,
  output logic [W-1:0]  y_o,
  output logic [ZW-1:0] z_o
);
  logic signed [W-1:0] xsh, ysh;
  logic pos;
  assign xsh = $signed(x_i) >>> sel_i;
  assign ysh = $signed(y_i) >>> sel_i;
  assign pos = ~z_i[ZW-1];
  assign x_o = pos ? x_i - ysh : x_i + ysh;
  assign y_o = pos ? y_i + xsh : y_i - xsh;
  assign z_o = pos ? z_i - atan_i : z_i + atan_i;
endmodule

// File: rtl/cordic_iter_rotate.sv
// cordic_iter_rotate: iterative rotation-mode CORDIC with quadrant pre-rotation
// and a valid/ready handshake on both sides; one micro-rotation per cycle.
module cordic_iter_rotate
  import cordic_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int ITER  = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] X_in,
  input  logic [DSIZE-1:0] Y_in,
  input  logic [DSIZE-1:0] Z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE+1:0] X_out,
  output logic [DSIZE+1:0] Y_out,
  output logic [DSIZE-1:0] Z_out,
  output logic [4:0]       sel_out
);
  localparam int W = DSIZE + 2;
  localparam int ITER_C = iter_clamp(ITER);
  localparam logic [4:0] LAST = 5'(ITER_C - 1);
  localparam logic signed [DSIZE-1:0] Q90 = DSIZE'(ang_90(DSIZE));
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic signed [W-1:0] x_q, y_q, x_d, y_d, xe, ye, xp, yp;
  logic signed [DSIZE-1:0] z_q, z_d, zp;
  logic [W-1:0] xr, yr, xo_q, yo_q;
  logic [DSIZE-1:0] zr, zo_q;
  logic [DSIZE-1:0] rom [32];
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, acc, fin, hi, lo;
  for (genvar g = 0; g < 32; g++) begin : g_rom
    assign rom[g] = DSIZE'(atan_tab(g, DSIZE));
  end
  assign acc = in_ready_q & in_valid;
  assign fin = state_q == ROT && cnt_q == LAST;
  assign xe = {{2{X_in[DSIZE-1]}}, X_in};
  assign ye = {{2{Y_in[DSIZE-1]}}, Y_in};
  // the angle never leaves +/-180 deg, so it stays DSIZE wide; -180 deg lands in lo
  assign hi = z_q > Q90;
  assign lo = z_q < -Q90;
  assign xp = hi ? -y_q : lo ? y_q : x_q;
  assign yp = hi ? x_q : lo ? -x_q : y_q;
  assign zp = hi ? z_q - Q90 : lo ? z_q + Q90 : z_q;
  cordic_micro_rotate #(.W(W), .ZW(DSIZE)) u_rot (
    .x_i(x_q), .y_i(y_q), .z_i(z_q), .atan_i(rom[cnt_q]), .sel_i(cnt_q),
    .x_o(xr), .y_o(yr), .z_o(zr)
  );
  always_comb begin
    x_d = acc ? xe : state_q == LOAD ? xp : state_q == ROT ? xr : x_q;
    y_d = acc ? ye : state_q == LOAD ? yp : state_q == ROT ? yr : y_q;
    z_d = acc ? Z_in : state_q == LOAD ? zp : state_q == ROT ? zr : z_q;
    cnt_d = state_q == ROT ? cnt_q + 5'd1 : 5'd0;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = acc ? LOAD : IDLE;
      LOAD:    state_d = ROT;
      ROT:     state_d = cnt_q == LAST ? HOLD : ROT;
      default: state_d = out_ready ? IDLE : HOLD;
    endcase
  end
  always_comb begin
    in_ready_d  = state_d == IDLE;
    out_valid_d = state_d == HOLD;
  end
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      xo_q        <= '0;
      yo_q        <= '0;
      zo_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      if (fin) begin
        xo_q <= xr;
        yo_q <= yr;
        zo_q <= zr;
      end
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign X_out     = xo_q;
  assign Y_out     = yo_q;
  assign Z_out     = zo_q;
  assign sel_out   = LAST;
endmodule

// File: tb/tb_cordic_iter_rotate.sv
// tb_cordic_iter_rotate: directed vectors with hand-computed CORDIC results
module tb_cordic_iter_rotate;
  logic clock = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] X_in = '0, Y_in = '0, Z_in = '0;
  logic in_ready, out_valid;
  logic [17:0] X_out, Y_out;
  logic [15:0] Z_out;
  logic [4:0] sel_out;
  int checks = 0, errors = 0;

  cordic_iter_rotate #(.DSIZE(16), .ITER(16)) dut (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X_in(X_in), .Y_in(Y_in), .Z_in(Z_in), .out_valid(out_valid),
    .out_ready(out_ready), .X_out(X_out), .Y_out(Y_out), .Z_out(Z_out),
    .sel_out(sel_out)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, int obs, int exp, int tol = 0);
    checks++;
    if ((obs > exp ? obs - exp : exp - obs) > tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic apply(int x, int y, int z, bit hold = 1'b0);
    int n = 0;
    X_in = 16'(x);
    Y_in = 16'(y);
    Z_in = 16'(z);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    @(posedge clock); #1;
    if (!hold) in_valid = 1'b0;
    check("accept_drops_ready", in_ready, 0);
  endtask

  task automatic wait_valid(string tag);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check(tag, lat, 17);
  endtask

  task automatic do_op(string tag, int x, int y, int z, int ex, int ey);
    apply(x, y, z);
    wait_valid({tag, "_lat"});
    check({tag, "_x"}, $signed(X_out), ex, 3);
    check({tag, "_y"}, $signed(Y_out), ey, 3);
    check({tag, "_z"}, $signed(Z_out), 0, 2);
  endtask

  task automatic release_out(string tag);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hx, hy, hz;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_x", X_out, 0);
    check("rst_y", Y_out, 0);
    check("rst_z", Z_out, 0);
    check("sel_rst", sel_out, 15);
    @(posedge clock); #1;
    rst = 1'b0;
    check("ready_low_at_release", in_ready, 0);
    @(posedge clock); #1;
    check("ready_rise", in_ready, 1);

    do_op("deg0", 1000, 0, 0, 1647, 0);
    release_out("deg0");
    do_op("deg30", 1000, 0, 5461, 1426, 823);
    release_out("deg30");
    do_op("deg120", 1000, 0, 21845, -823, 1426);
    release_out("deg120");
    do_op("deg_m180", 1000, 0, -32768, -1647, 0);
    release_out("deg_m180");
    do_op("deg_m90", 1000, 0, -16384, 0, -1647);
    release_out("deg_m90");

    // backpressure: results frozen for 10 cycles
    do_op("hold", 1000, 0, 5461, 1426, 823);
    hx = $signed(X_out);
    hy = $signed(Y_out);
    hz = $signed(Z_out);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      check("hold_x", $signed(X_out), hx);
      check("hold_y", $signed(Y_out), hy);
      check("hold_z", $signed(Z_out), hz);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
    end
    release_out("hold");

    // reset in the middle of iteration 7
    apply(500, 0, 0);
    repeat (8) @(posedge clock);
    #1 rst = 1'b1;
    #1;
    check("midrst_x", X_out, 0);
    check("midrst_y", Y_out, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    repeat (25) @(posedge clock);
    #1;
    check("midrst_no_result", out_valid, 0);
    do_op("post_rst", 1000, 0, 5461, 1426, 823);
    release_out("post_rst");

    // in_valid held high: second operand taken only after handshake
    apply(1000, 0, 0, 1'b1);
    Z_in = 16'(5461);
    wait_valid("b2b1_lat");
    check("b2b1_x", $signed(X_out), 1647, 3);
    check("b2b1_y", $signed(Y_out), 0, 3);
    check("b2b1_ready", in_ready, 0);
    check("b2b_sel", sel_out, 15);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("b2b_ready_after_hs", in_ready, 1);
    check("b2b_valid_after_hs", out_valid, 0);
    @(posedge clock); #1;
    check("b2b2_accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_valid("b2b2_lat");
    check("b2b2_x", $signed(X_out), 1426, 3);
    check("b2b2_y", $signed(Y_out), 823, 3);
    check("b2b2_sel", sel_out, 15);
    release_out("b2b2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
